per_slave_regfile: RTL and testbench
====================================

// Module: per_slave_regfile
// PURPOSE
//   Peripheral-protocol target holding N_REGS 32-bit control/status registers.
//   Sits directly downstream of the APB-to-peripheral bridge.
//   Consumes its req/add/we/wdata/be stream and returns gnt, r_valid, r_opc and r_rdata.
//   Register contents are exported flat to drive local hardware.
//   One transaction in flight at a time; the grant can be held off by programmable wait states.
// PARAMETERS
//   PER_ADDR_WIDTH  32            width of per_slave_add_i
//   BASE_ADDR       32'h1A10_0000 byte address of register 0
//   N_REGS          8             number of registers, 2..64; register 0 is the read-only ID
//   ID_VALUE        32'h5EC0_0001 value returned by register 0
//   GNT_WAIT        0             cycles req is held before gnt; 0..15
// PORTS
//   clk_i              in   1             clock, rising edge
//   rst_ni             in   1             asynchronous reset, active low
//   per_slave_req_i    in   1             request, held by master until gnt
//   per_slave_add_i    in   PER_ADDR_WIDTH byte address
//   per_slave_we_i     in   1             1=write 0=read
//   per_slave_wdata_i  in   32            write data
//   per_slave_be_i     in   4             byte enables, bit k -> wdata[8k+7:8k]
//   per_slave_gnt_o    out  1             grant; transaction accepted at this clock edge
//   per_slave_r_valid_o out 1             response valid, one cycle pulse
//   per_slave_r_opc_o  out  1             response error flag (1=error)
//   per_slave_r_rdata_o out 32            read data
//   regs_o             out  N_REGS*32     register image; reg i at [32i+31:32i]
// BEHAVIOUR
//   Reset: r_valid_o=0, r_opc_o=0, r_rdata_o=0, regs 1..N_REGS-1=0,
//     regs_o[31:0]=ID_VALUE, wait counter=0, state IDLE.
//   States:
//   - IDLE: if req && GNT_WAIT==0, gnt_o=1 combinationally and go to RESP.
//       If req && GNT_WAIT>0, load cnt=GNT_WAIT-1 and go to WAIT.
//   - WAIT: gnt_o=0 while cnt!=0; cnt decrements each cycle.
//       gnt_o=1 when cnt==0 && req, then go to RESP.
//       If req drops, return to IDLE and clear cnt; no response is issued.
//   - RESP: r_valid_o=1 for exactly this cycle, gnt_o=0; return to IDLE.
//       Back-to-back transactions therefore occur at most every 2 cycles
//       (GNT_WAIT=0).
//   Latency: r_valid_o is exactly 1 cycle after the gnt edge, for reads and
//     writes alike. r_opc_o and r_rdata_o are registered at the gnt edge and
//     held until the next gnt.
//   Decode: off = add - BASE_ADDR (PER_ADDR_WIDTH, unsigned); idx = off>>2.
//     The access is in range iff add>=BASE_ADDR, off[1:0]==0 and idx<N_REGS.
//   Read in range: r_rdata = reg[idx] (ID_VALUE for idx 0), r_opc=0.
//   Write in range, idx!=0: per byte, reg[idx] byte k <= wdata byte k if be[k].
//     Update happens at the gnt edge, so regs_o changes 1 cycle after gnt.
//     r_rdata=0, r_opc=0. be=4'b0000 is a legal no-op write (r_opc=0).
//   Write to idx 0: no register change, r_opc=1, r_rdata=0.
//   Out of range or misaligned: no register change, r_opc=1,
//     r_rdata=32'hDEAD_BEEF for reads and 0 for writes.
//   Ordering: a read granted after a write sees the written value.
//   Address inputs are only sampled at the gnt edge; changes while waiting
//     are ignored.
//   Async reset mid-transaction: state returns to IDLE, any pending response
//     is dropped, registers reset; gnt_o follows req && (GNT_WAIT==0) while
//     rst_ni is low.
// TESTING
//   1. Reset, GNT_WAIT=0: read BASE_ADDR -> gnt same cycle as req;
//      r_valid 1 cycle later; rdata=32'h5EC0_0001, opc=0.
//   2. Write BASE+4 wdata=32'hA5A5_1234 be=4'b0101, then read BASE+4 ->
//      rdata=32'h00A5_0034; regs_o[63:32] updates 1 cycle after gnt.
//   3. Read BASE+8*4 (N_REGS=8), then read BASE+6 ->
//      opc=1, rdata=32'hDEAD_BEEF for both; no reg change.
//   4. Write BASE+0 with 32'hFFFF_FFFF -> opc=1; subsequent read still returns 32'h5EC0_0001.
//   5. GNT_WAIT=3: req held -> gnt on the 4th cycle of req, r_valid on the 5th;
//      req dropped after 2 cycles -> no gnt, no r_valid, IDLE.
//   6. Assert rst_ni low in RESP cycle of write to BASE+4 -> r_valid=0 next cycle, regs_o[63:32]=0.

Source files
------------

// File: rtl/per_slave_regfile.sv
// Peripheral-protocol register target: N_REGS x 32-bit control/status registers
// behind a req/gnt handshake with optional grant wait states; register 0 is a read-only ID.
module per_slave_regfile #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h1A10_0000,
    parameter int unsigned N_REGS         = 8,
    parameter logic [31:0] ID_VALUE       = 32'h5EC0_0001,
    parameter int unsigned GNT_WAIT       = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [31:0]               per_slave_r_rdata_o,
    output logic [N_REGS*32-1:0]      regs_o
);

    localparam int unsigned AW    = PER_ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       regs_q [1:N_REGS-1];

    logic [AW-1:0]     off;
    logic [AW-1:0]     idx;
    logic              in_range;
    logic              gnt_c;
    logic [31:0]       rd_word;

    // Address decode relative to the register window
    assign off      = per_slave_add_i - BASE;
    assign idx      = off >> 2;
    assign in_range = (per_slave_add_i >= BASE) && (off[1:0] == 2'b00) && (idx < AW'(N_REGS));

    always_comb begin
        rd_word = ID_VALUE;
        for (int i = 1; i < int'(N_REGS); i++) begin
            if (idx == AW'(i)) rd_word = regs_q[i];
        end
    end

    // Grant is combinational so a zero-wait access is accepted in the request cycle
    always_comb begin
        gnt_c = 1'b0;
        case (state_q)
            IDLE:    gnt_c = per_slave_req_i && (GNT_WAIT == 0);
            WAIT:    gnt_c = per_slave_req_i && (cnt_q == '0);
            default: gnt_c = 1'b0;
        endcase
    end

    assign per_slave_gnt_o = gnt_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            per_slave_r_valid_o <= 1'b0;
            per_slave_r_opc_o   <= 1'b0;
            per_slave_r_rdata_o <= '0;
            for (int i = 1; i < int'(N_REGS); i++) regs_q[i] <= '0;
        end else begin
            per_slave_r_valid_o <= gnt_c;
            case (state_q)
                IDLE: begin
                    if (per_slave_req_i) begin
                        if (GNT_WAIT == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_W'(GNT_WAIT - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!per_slave_req_i) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Response and register update are both taken at the grant edge
            if (gnt_c) begin
                if (per_slave_we_i) begin
                    per_slave_r_rdata_o <= '0;
                    per_slave_r_opc_o   <= !in_range || (idx == '0);
                    for (int i = 1; i < int'(N_REGS); i++) begin
                        if (in_range && (idx == AW'(i))) begin
                            for (int k = 0; k < 4; k++) begin
                                if (per_slave_be_i[k]) regs_q[i][8*k +: 8] <= per_slave_wdata_i[8*k +: 8];
                            end
                        end
                    end
                end else begin
                    per_slave_r_opc_o   <= !in_range;
                    per_slave_r_rdata_o <= in_range ? rd_word : 32'hDEAD_BEEF;
                end
            end
        end
    end

    assign regs_o[31:0] = ID_VALUE;
    for (genvar g = 1; g < int'(N_REGS); g++) begin : g_regs
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_per_slave_regfile.sv
// Directed self-checking bench for per_slave_regfile: a zero-wait instance and
// a three-wait-state instance share the clock, reset and address/data bus.
module tb_per_slave_regfile;

    localparam logic [31:0] BASE = 32'h1A10_0000;
    localparam logic [31:0] ID   = 32'h5EC0_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req3;
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        gnt0, rv0, opc0;
    logic [31:0] rd0;
    logic [255:0] regs0;
    logic        gnt3, rv3, opc3;
    logic [31:0] rd3;
    logic [255:0] regs3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    per_slave_regfile #(.GNT_WAIT(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .per_slave_req_i(req0), .per_slave_add_i(add),
        .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
        .per_slave_gnt_o(gnt0), .per_slave_r_valid_o(rv0), .per_slave_r_opc_o(opc0),
        .per_slave_r_rdata_o(rd0), .regs_o(regs0)
    );

    per_slave_regfile #(.GNT_WAIT(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .per_slave_req_i(req3), .per_slave_add_i(add),
        .per_slave_we_i(we), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
        .per_slave_gnt_o(gnt3), .per_slave_r_valid_o(rv3), .per_slave_r_opc_o(opc3),
        .per_slave_r_rdata_o(rd3), .regs_o(regs3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One zero-wait transaction on dut0: gnt in the request cycle, response one cycle later
    task automatic txn0(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic exp_opc, input logic [31:0] exp_rd);
        @(negedge clk);
        req0 = 1'b1; we = w; add = a; wdata = d; be = b;
        #1 chk({tag, ".gnt"}, 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        chk({tag, ".rvalid"}, 32'(rv0), 32'd1);
        chk({tag, ".opc"}, 32'(opc0), 32'(exp_opc));
        chk({tag, ".rdata"}, rd0, exp_rd);
        @(posedge clk); #1;
        chk({tag, ".rvalid_drop"}, 32'(rv0), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0;
        add = '0; we = 1'b0; wdata = '0; be = '0;
        #2;
        chk("rst.rvalid", 32'(rv0), 32'd0);
        chk("rst.opc", 32'(opc0), 32'd0);
        chk("rst.rdata", rd0, 32'd0);
        chk("rst.reg0", regs0[31:0], ID);
        chk("rst.reg1", regs0[63:32], 32'd0);
        chk("rst.gnt", 32'(gnt0), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ID read, byte-enabled write and readback
        txn0("rd_id", 1'b0, BASE, 32'h0, 4'h0, 1'b0, ID);
        txn0("wr_r1", 1'b1, BASE + 4, 32'hA5A5_1234, 4'b0101, 1'b0, 32'h0);
        chk("wr_r1.regs", regs0[63:32], 32'h00A5_0034);
        txn0("rd_r1", 1'b0, BASE + 4, 32'h0, 4'h0, 1'b0, 32'h00A5_0034);

        // Out of range, misaligned, below base
        txn0("rd_oor", 1'b0, BASE + 32, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        txn0("rd_mis", 1'b0, BASE + 6, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        txn0("rd_low", 1'b0, BASE - 4, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        txn0("wr_oor", 1'b1, BASE + 32, 32'h1111_2222, 4'hF, 1'b1, 32'h0);
        chk("oor.regs1", regs0[63:32], 32'h00A5_0034);
        chk("oor.regs7", regs0[255:224], 32'h0);

        // ID register is not writable
        txn0("wr_id", 1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
        txn0("rd_id2", 1'b0, BASE, 32'h0, 4'h0, 1'b0, ID);
        chk("wr_id.regs0", regs0[31:0], ID);

        // No-op write with be=0 and last-register full write
        txn0("wr_be0", 1'b1, BASE + 8, 32'hCAFE_F00D, 4'b0000, 1'b0, 32'h0);
        chk("wr_be0.regs2", regs0[95:64], 32'h0);
        txn0("wr_r7", 1'b1, BASE + 28, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0);
        txn0("rd_r7", 1'b0, BASE + 28, 32'h0, 4'h0, 1'b0, 32'h1357_9BDF);
        chk("rd_r7.hold", rd0, 32'h1357_9BDF);

        // Three wait states: gnt on the 4th request cycle; address only sampled at gnt
        @(negedge clk);
        req3 = 1'b1; we = 1'b0; add = BASE + 32;
        #1 chk("w3.c1.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("w3.c2.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("w3.c3.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1;
        add = BASE;
        chk("w3.c4.gnt", 32'(gnt3), 32'd1);
        chk("w3.c4.rvalid", 32'(rv3), 32'd0);
        @(posedge clk); #1;
        req3 = 1'b0;
        chk("w3.c5.rvalid", 32'(rv3), 32'd1);
        chk("w3.c5.opc", 32'(opc3), 32'd0);
        chk("w3.c5.rdata", rd3, ID);
        @(posedge clk); #1 chk("w3.c6.rvalid", 32'(rv3), 32'd0);

        // Request withdrawn after two cycles: no grant, no response
        req3 = 1'b1;
        #1 chk("ab.c1.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("ab.c2.gnt", 32'(gnt3), 32'd0);
        req3 = 1'b0;
        @(posedge clk); #1 chk("ab.gnt", 32'(gnt3), 32'd0);
        chk("ab.rvalid", 32'(rv3), 32'd0);
        @(posedge clk); #1 chk("ab.rvalid2", 32'(rv3), 32'd0);

        // After the abort the counter restarts from the full wait
        req3 = 1'b1;
        #1 chk("re.c1.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("re.c2.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("re.c3.gnt", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("re.c4.gnt", 32'(gnt3), 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        chk("re.rvalid", 32'(rv3), 32'd1);

        // Reset asserted during the response cycle of a write
        @(negedge clk);
        req0 = 1'b1; we = 1'b1; add = BASE + 4; wdata = 32'h1234_5678; be = 4'hF;
        @(posedge clk); #1;
        chk("rr.rvalid", 32'(rv0), 32'd1);
        chk("rr.regs1", regs0[63:32], 32'h1234_5678);
        rst_n = 1'b0; req3 = 1'b1;
        #1;
        chk("rr.rvalid_rst", 32'(rv0), 32'd0);
        chk("rr.regs1_rst", regs0[63:32], 32'd0);
        chk("rr.regs7_rst", regs0[255:224], 32'd0);
        chk("rr.gnt0_rst", 32'(gnt0), 32'd1);
        chk("rr.gnt3_rst", 32'(gnt3), 32'd0);
        @(posedge clk); #1 chk("rr.rvalid_next", 32'(rv0), 32'd0);
        req0 = 1'b0; req3 = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        txn0("rr.rd_r1", 1'b0, BASE + 4, 32'h0, 4'h0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
